// File: rtl/flit_rx_fifo_pkg.sv
// rtl/flit_rx_fifo_pkg.sv - flit layout, widths and checksum helper shared by the link receive and transmit sides
package flit_rx_fifo_pkg;

  localparam int FLIT_WIDTH     = 64;
  localparam int CHECKSUM_WIDTH = 8;

  typedef struct packed {
    logic [1:0]  ftype;
    logic [7:0]  src_id;
    logic [7:0]  dst_id;
    logic [37:0] payload;
    logic [7:0]  checksum;
  } flit_t;

  // XOR of bytes 7..1; byte 0 carries the checksum itself.
  function automatic logic [CHECKSUM_WIDTH-1:0] flit_checksum(input flit_t f);
    logic [FLIT_WIDTH-1:0]     bits;
    logic [CHECKSUM_WIDTH-1:0] x;
    bits = f;
    x    = '0;
    for (int i = 1; i < FLIT_WIDTH / CHECKSUM_WIDTH; i++) begin
      x = x ^ bits[i*CHECKSUM_WIDTH +: CHECKSUM_WIDTH];
    end
    return x;
  endfunction

endpackage

// File: rtl/flit_checksum_check.sv
// rtl/flit_checksum_check.sv - combinational flit checksum verifier
module flit_checksum_check
  import flit_rx_fifo_pkg::*;
(
  input  logic [FLIT_WIDTH-1:0] flit,
  output logic                  ok
);

  flit_t f;

  always_comb begin
    f  = flit;
    ok = (f.checksum == flit_checksum(f));
  end

endmodule

// File: rtl/flit_rx_fifo.sv
// rtl/flit_rx_fifo.sv - receive buffer: checksum filter in front of a first-word-fall-through FIFO
module flit_rx_fifo
  import flit_rx_fifo_pkg::*;
#(
  parameter int DEPTH          = 8,
  parameter int DROP_CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [FLIT_WIDTH-1:0]     in_flit,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [FLIT_WIDTH-1:0]     out_flit,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      full,
  output logic                      empty,
  output logic [DROP_CNT_WIDTH-1:0] drop_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
      $error("flit_rx_fifo: DEPTH must be a power of two and at least 2");
    end
  endgenerate

  logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]            count_q, count_d;
  logic [DROP_CNT_WIDTH-1:0] drop_q, drop_d;
  logic [FLIT_WIDTH-1:0]     mem_q [DEPTH];

  logic flit_ok;
  logic accept;
  logic wr_en;
  logic pop;

  flit_checksum_check u_chk (
    .flit (in_flit),
    .ok   (flit_ok)
  );

  assign full       = (count_q == FULL_CNT);
  assign empty      = (count_q == '0);
  assign in_ready   = !full;
  assign out_valid  = !empty;
  assign out_flit   = mem_q[rd_ptr_q];
  assign drop_count = drop_q;

  // A bad flit still completes the handshake; it just never reaches the array.
  assign accept = in_valid && in_ready;
  assign wr_en  = accept && flit_ok;
  assign pop    = out_valid && out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    drop_d   = drop_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (accept && !flit_ok && drop_q != '1) drop_d = drop_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      drop_q   <= drop_d;
    end
  end

  // Storage is deliberately unreset; count gates its visibility.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= in_flit;
  end

endmodule
